// File: rtl/mmio_bus_pkg.sv
// Shared definitions for the CPU data-side bus: MMIO register offsets, TCON bit
// positions and the active-low 7-segment hex decoder.
package mmio_bus_pkg;

  localparam logic [5:0] OFF_TH      = 6'h00;
  localparam logic [5:0] OFF_TL      = 6'h04;
  localparam logic [5:0] OFF_TCON    = 6'h08;
  localparam logic [5:0] OFF_LED     = 6'h0C;
  localparam logic [5:0] OFF_DISP    = 6'h10;
  localparam logic [5:0] OFF_SYSTICK = 6'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'h0:    seg_decode = 7'b1000000;
      4'h1:    seg_decode = 7'b1111001;
      4'h2:    seg_decode = 7'b0100100;
      4'h3:    seg_decode = 7'b0110000;
      4'h4:    seg_decode = 7'b0011001;
      4'h5:    seg_decode = 7'b0010010;
      4'h6:    seg_decode = 7'b0000010;
      4'h7:    seg_decode = 7'b1111000;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0010000;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b0000011;
      4'hC:    seg_decode = 7'b1000110;
      4'hD:    seg_decode = 7'b0100001;
      4'hE:    seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/seg_scanner.sv
// Multiplexed 7-segment scanner: steps one digit every SCAN_DIV clocks and
// drives the active-low digit enable plus the decoded segments for that digit.
module seg_scanner
  import mmio_bus_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter logic [15:0] SCAN_DIV   = 16'd50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              segs
);

  localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [15:0]      div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    div_d = div_q + 16'd1;
    idx_d = idx_q;
    if (div_q == SCAN_DIV - 16'd1) begin
      div_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  assign an   = ~(NUM_DIGITS'(1) << idx_q);
  assign segs = seg_decode(digits[{idx_q, 2'b00} +: 4]);

endmodule

// File: rtl/mmio_bus.sv
// CPU data-side bus: routes loads/stores to data memory or the MMIO window
// (timer, LED, display, systick). Define MMIO_BUS_SCAN_EN for the digit scanner.
module mmio_bus
  import mmio_bus_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE  = 32'h4000_0000,
  parameter int          LED_W      = 8,
  parameter int          NUM_DIGITS = 4,
  parameter logic [15:0] SCAN_DIV   = 16'd50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  word_acc,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  dm_wen,
  output logic                  dm_ren,
  output logic [31:0]           dm_addr,
  output logic [31:0]           dm_wdata,
  output logic                  dm_word,
  input  logic [31:0]           dm_rdata,
  output logic                  irq,
  output logic [LED_W-1:0]      leds_o,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            segs
);

  logic             mmio_sel, aligned, mmio_wr;
  logic [5:0]       offset;
  logic             tl_ovf, st_hw_set;
  logic [31:0]      th_q, th_d, tl_q, tl_d, disp_q, disp_d, systick_q, systick_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      mmio_rdata;

  assign mmio_sel = (addr[31:6] == MMIO_BASE[31:6]);
  assign offset   = addr[5:0];
  assign aligned  = (addr[1:0] == 2'b00);
  assign mmio_wr  = wr_en & mmio_sel & word_acc & aligned;

  assign dm_wen   = wr_en & ~mmio_sel;
  assign dm_ren   = rd_en & ~mmio_sel;
  assign dm_addr  = addr;
  assign dm_wdata = wdata;
  assign dm_word  = word_acc;

  assign tl_ovf    = tcon_q[TCON_EN] & (tl_q == '1);
  assign st_hw_set = tl_ovf & tcon_q[TCON_IE];

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    disp_d    = disp_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[TCON_EN]) tl_d = tl_ovf ? th_q : tl_q + 32'd1;
    if (st_hw_set) tcon_d[TCON_ST] = 1'b1;

    // CPU stores override the hardware update, except that a pending overflow keeps ST set.
    if (mmio_wr) begin
      case (offset)
        OFF_TH:   th_d = wdata;
        OFF_TL:   tl_d = wdata;
        OFF_TCON: begin
          tcon_d = wdata[2:0];
          if (st_hw_set) tcon_d[TCON_ST] = 1'b1;
        end
        OFF_LED:  led_d  = wdata[LED_W-1:0];
        OFF_DISP: disp_d = wdata;
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      disp_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      disp_q    <= disp_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (aligned) begin
      case (offset)
        OFF_TH:      mmio_rdata = th_q;
        OFF_TL:      mmio_rdata = tl_q;
        OFF_TCON:    mmio_rdata = {29'd0, tcon_q};
        OFF_LED:     mmio_rdata = 32'(led_q);
        OFF_DISP:    mmio_rdata = disp_q;
        OFF_SYSTICK: mmio_rdata = systick_q;
        default:     mmio_rdata = '0;
      endcase
    end
  end

  assign rdata  = !rd_en ? 32'd0 : (dm_ren ? dm_rdata : mmio_rdata);
  assign irq    = tcon_q[TCON_IE] & tcon_q[TCON_ST];
  assign leds_o = led_q;

`ifdef MMIO_BUS_SCAN_EN
  seg_scanner #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_seg_scanner (
    .clk    (clk),
    .reset  (reset),
    .digits (disp_q[4*NUM_DIGITS-1:0]),
    .an     (an),
    .segs   (segs)
  );
`else
  // Raw display: software drives the digit enables and segments directly.
  logic [15:0] unused_scan_div;
  assign unused_scan_div = SCAN_DIV;
  assign an   = disp_q[8 +: NUM_DIGITS];
  assign segs = disp_q[6:0];
`endif

endmodule

// File: tb/tb_mmio_bus.sv
// Self-checking bench for mmio_bus: directed scenarios plus randomized traffic
// compared against a register-level reference model; works with or without MMIO_BUS_SCAN_EN.
module tb_mmio_bus;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam int          LED_W  = 8;
  localparam int          ND     = 4;
  localparam logic [15:0] SDIV   = 16'd2;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED  = BASE + 32'h0C;
  localparam logic [31:0] A_DISP = BASE + 32'h10;
  localparam logic [31:0] A_TICK = BASE + 32'h14;
  localparam logic [6:0]  SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef MMIO_BUS_SCAN_EN
  localparam logic [ND-1:0] RST_AN   = 4'hE;
  localparam logic [6:0]    RST_SEGS = 7'h40;
`else
  localparam logic [ND-1:0] RST_AN   = '0;
  localparam logic [6:0]    RST_SEGS = '0;
`endif

  logic             clk = 1'b0, reset = 1'b1;
  logic             wr_en = 1'b0, rd_en = 1'b0, word_acc = 1'b1;
  logic [31:0]      addr = '0, wdata = '0, dm_rdata = '0;
  logic [31:0]      rdata, dm_addr, dm_wdata;
  logic             dm_wen, dm_ren, dm_word, irq;
  logic [LED_W-1:0] leds_o;
  logic [ND-1:0]    an;
  logic [6:0]       segs;
  int               n_checks = 0, n_errors = 0;

  mmio_bus #(
    .MMIO_BASE (BASE), .LED_W (LED_W), .NUM_DIGITS (ND), .SCAN_DIV (SDIV)
  ) dut (
    .clk (clk), .reset (reset), .wr_en (wr_en), .rd_en (rd_en), .word_acc (word_acc),
    .addr (addr), .wdata (wdata), .rdata (rdata), .dm_wen (dm_wen), .dm_ren (dm_ren),
    .dm_addr (dm_addr), .dm_wdata (dm_wdata), .dm_word (dm_word), .dm_rdata (dm_rdata),
    .irq (irq), .leds_o (leds_o), .an (an), .segs (segs)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // Reference model: architectural register contents and scanner position.
  logic [31:0]      m_th, m_tl, m_disp, m_tick;
  bit               m_en, m_ie, m_st;
  logic [LED_W-1:0] m_led;
  int               m_idx, m_div;
  logic [31:0]      mem [logic [31:0]];

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_disp = 0; m_tick = 0; m_led = 0;
    m_en = 0; m_ie = 0; m_st = 0; m_idx = 0; m_div = 0;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a - BASE) < 32'd64;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    if (off[1:0] != 2'b00) return 32'd0;
    case (off)
      32'h00:  return m_th;
      32'h04:  return m_tl;
      32'h08:  return {29'd0, m_st, m_ie, m_en};
      32'h0C:  return 32'(m_led);
      32'h10:  return m_disp;
      32'h14:  return m_tick;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!rd_en) return 32'd0;
    if (!in_win(addr)) return dm_rdata;
    return m_read(addr);
  endfunction

  function automatic logic [ND-1:0] exp_an();
`ifdef MMIO_BUS_SCAN_EN
    logic [ND-1:0] one = 1;
    return ~(one << m_idx);
`else
    return m_disp[8 +: ND];
`endif
  endfunction

  function automatic logic [6:0] exp_segs();
`ifdef MMIO_BUS_SCAN_EN
    logic [3:0] nib = m_disp[4*m_idx +: 4];
    return SEG_TAB[nib];
`else
    return m_disp[6:0];
`endif
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit          ovf  = m_en && (m_tl == 32'hFFFF_FFFF);
    logic [31:0] n_tl = m_en ? (ovf ? m_th : m_tl + 32'd1) : m_tl;
    bit          n_st = m_st | (ovf & m_ie);
    bit          n_en = m_en, n_ie = m_ie;
    logic [31:0] off  = addr - BASE;
    if (wr_en && in_win(addr) && word_acc && addr[1:0] == 2'b00) begin
      case (off)
        32'h00: m_th = wdata;
        32'h04: n_tl = wdata;
        32'h08: begin n_en = wdata[0]; n_ie = wdata[1]; n_st = wdata[2] | (ovf & m_ie); end
        32'h0C: m_led = wdata[LED_W-1:0];
        32'h10: m_disp = wdata;
        default: ;
      endcase
    end
    if (wr_en && !in_win(addr)) mem[addr] = wdata;
    m_tl = n_tl; m_st = n_st; m_en = n_en; m_ie = n_ie;
    m_tick = m_tick + 32'd1;
    if (m_div == int'(SDIV) - 1) begin m_div = 0; m_idx = (m_idx + 1) % ND; end
    else m_div = m_div + 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // NOTE: stimulus is driven with blocking assignments, well away from the active edge.
  task automatic drive(input bit w, input bit r, input bit wd, input logic [31:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; word_acc = wd; addr = a; wdata = d;
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit wd = 1'b1);
    drive(1'b1, 1'b0, wd, a, d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] regs [6] = '{A_TH, A_TL, A_TCON, A_LED, A_DISP, A_TICK};
    foreach (regs[i]) begin
      drive(1'b0, 1'b1, 1'b1, regs[i], 32'd0);
      n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL reset_reg[%0d]: rdata=%h want 0", i, rdata); end
    end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_checks++; if (leds_o !== '0) begin n_errors++; $display("FAIL reset_leds: got %h want 0", leds_o); end
    n_checks++; if (an !== RST_AN) begin n_errors++; $display("FAIL reset_an: got %h want %h", an, RST_AN); end
    n_checks++; if (segs !== RST_SEGS) begin n_errors++; $display("FAIL reset_segs: got %h want %h", segs, RST_SEGS); end
  endtask

  task automatic test_mem_route();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_1234);
    n_checks++; if (dm_wen !== 1'b1 || dm_ren !== 1'b0) begin n_errors++; $display("FAIL mem_store_en: wen=%b ren=%b want 1 0", dm_wen, dm_ren); end
    n_checks++; if (dm_addr !== 32'h100 || dm_wdata !== 32'h1234 || dm_word !== 1'b1) begin
      n_errors++; $display("FAIL mem_store_pass: addr=%h wdata=%h word=%b want 100 1234 1", dm_addr, dm_wdata, dm_word); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'd0);
    n_checks++; if (dm_wen !== 1'b0) begin n_errors++; $display("FAIL mem_store_pulse: wen=%b want 0", dm_wen); end
    dm_rdata = mem[32'h100];
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'd0);
    n_checks++; if (dm_ren !== 1'b1 || rdata !== 32'h1234) begin n_errors++; $display("FAIL mem_load: ren=%b rdata=%h want 1 1234", dm_ren, rdata); end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'd0);
    n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL idle_rdata: got %h want 0", rdata); end
    drive(1'b1, 1'b0, 1'b1, 32'h4000_0100, 32'h1234);
    n_checks++; if (dm_wen !== 1'b1) begin n_errors++; $display("FAIL outside_window: wen=%b want 1", dm_wen); end
    tick();
    drive(1'b1, 1'b0, 1'b0, A_TH, 32'h0);
    n_checks++; if (dm_wen !== 1'b0 || dm_word !== 1'b0) begin n_errors++; $display("FAIL mmio_no_mem: wen=%b word=%b want 0 0", dm_wen, dm_word); end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_timer();
    bus_write(A_TCON, 32'd0);
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    drive(1'b0, 1'b1, 1'b1, A_TL, 32'd0);
    n_checks++; if (irq !== 1'b0 || rdata !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL tmr_start: irq=%b tl=%h want 0 fffffffe", irq, rdata); end
    tick();
    n_checks++; if (irq !== 1'b0 || rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL tmr_count: irq=%b tl=%h want 0 ffffffff", irq, rdata); end
    tick();
    n_checks++; if (irq !== 1'b1 || rdata !== 32'hFFFF_FFF0) begin n_errors++; $display("FAIL tmr_reload: irq=%b tl=%h want 1 fffffff0", irq, rdata); end
    drive(1'b0, 1'b1, 1'b1, A_TCON, 32'd0);
    n_checks++; if (rdata !== 32'd7) begin n_errors++; $display("FAIL tmr_st: tcon=%h want 7", rdata); end
    bus_write(A_TCON, 32'd0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    tick();
    bus_write(A_TCON, 32'd3);
    drive(1'b0, 1'b1, 1'b1, A_TCON, 32'd0);
    n_checks++; if (rdata !== 32'd7 || irq !== 1'b1) begin n_errors++; $display("FAIL tcon_race: tcon=%h irq=%b want 7 1", rdata, irq); end
  endtask

  task automatic test_tl_write();
    bus_write(A_TCON, 32'd0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    tick();
    bus_write(A_TL, 32'd5);
    drive(1'b0, 1'b1, 1'b1, A_TL, 32'd0);
    n_checks++; if (rdata !== 32'd5) begin n_errors++; $display("FAIL tl_race: tl=%h want 5", rdata); end
    bus_write(A_TCON, 32'd0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'd1);
    tick();
    drive(1'b0, 1'b1, 1'b1, A_TL, 32'd0);
    n_checks++; if (rdata !== 32'hFFFF_FFF0 || irq !== 1'b0) begin n_errors++; $display("FAIL ie0_reload: tl=%h irq=%b want fffffff0 0", rdata, irq); end
    drive(1'b0, 1'b1, 1'b1, A_TCON, 32'd0);
    n_checks++; if (rdata !== 32'd1) begin n_errors++; $display("FAIL ie0_tcon: tcon=%h want 1", rdata); end
    bus_write(A_TCON, 32'd0);
  endtask

  task automatic test_led();
    bus_write(A_LED, 32'h3C);
    drive(1'b1, 1'b0, 1'b0, A_LED, 32'hFF);
    n_checks++; if (dm_wen !== 1'b0) begin n_errors++; $display("FAIL led_byte_wen: wen=%b want 0", dm_wen); end
    tick();
    wr_en = 1'b0;
    n_checks++; if (leds_o !== 8'h3C) begin n_errors++; $display("FAIL led_byte_ignored: leds=%h want 3c", leds_o); end
    bus_write(A_LED, 32'h1A5);
    n_checks++; if (leds_o !== 8'hA5) begin n_errors++; $display("FAIL led_word: leds=%h want a5", leds_o); end
    drive(1'b0, 1'b1, 1'b0, A_LED, 32'd0);
    n_checks++; if (rdata !== 32'hA5) begin n_errors++; $display("FAIL led_byte_read: rdata=%h want a5", rdata); end
    drive(1'b0, 1'b1, 1'b1, BASE + 32'h18, 32'd0);
    n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL unmapped_read: rdata=%h want 0", rdata); end
    drive(1'b0, 1'b1, 1'b1, BASE + 32'h0D, 32'd0);
    n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL misaligned_read: rdata=%h want 0", rdata); end
    bus_write(BASE + 32'h0D, 32'h11);
    n_checks++; if (leds_o !== 8'hA5) begin n_errors++; $display("FAIL misaligned_write: leds=%h want a5", leds_o); end
  endtask

  task automatic test_display();
`ifdef MMIO_BUS_SCAN_EN
    bus_write(A_DISP, 32'h4321);
    drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    for (int c = 0; c < 16; c++) begin
      n_checks++; if (an !== exp_an() || segs !== exp_segs()) begin
        n_errors++; $display("FAIL scan[%0d]: an=%h segs=%h want %h %h", c, an, segs, exp_an(), exp_segs()); end
      tick();
    end
`else
    bus_write(A_DISP, 32'h0B7F);
    n_checks++; if (an !== 4'hB || segs !== 7'h7F) begin n_errors++; $display("FAIL raw_disp: an=%h segs=%h want b 7f", an, segs); end
`endif
  endtask

  task automatic test_systick();
    drive(1'b0, 1'b1, 1'b1, A_TICK, 32'd0);
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (rdata !== m_tick) begin n_errors++; $display("FAIL systick[%0d]: got %h want %h", c, rdata, m_tick); end
      tick();
    end
    bus_write(A_TICK, 32'hDEAD_0000);
    drive(1'b0, 1'b1, 1'b1, A_TICK, 32'd0);
    n_checks++; if (rdata !== m_tick) begin n_errors++; $display("FAIL systick_ro: got %h want %h", rdata, m_tick); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    int unsigned sel, op;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 13);
      case (sel)
        0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * sel);
        6:       a = BASE + 32'h18;
        7:       a = BASE + 32'h3C;
        8:       a = BASE + 32'(4 * $urandom_range(0, 5) + $urandom_range(1, 3));
        9:       a = BASE + 32'h40;
        10:      a = BASE - 32'd4;
        default: a = 32'h100 + 32'(4 * $urandom_range(0, 63));
      endcase
      d = (sel == 1 && $urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      op = $urandom_range(0, 9);
      dm_rdata = $urandom;
      drive(op < 4, op >= 4 && op < 8, $urandom_range(0, 3) != 0, a, d);
      n_checks++; if (rdata !== exp_rdata()) begin n_errors++; $display("FAIL rnd_rdata[%0d]: addr=%h got %h want %h", i, a, rdata, exp_rdata()); end
      n_checks++; if (dm_wen !== (wr_en && !in_win(a)) || dm_ren !== (rd_en && !in_win(a))) begin
        n_errors++; $display("FAIL rnd_dm_en[%0d]: addr=%h wen=%b ren=%b", i, a, dm_wen, dm_ren); end
      n_checks++; if (irq !== (m_ie & m_st)) begin n_errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq, m_ie & m_st); end
      n_checks++; if (leds_o !== m_led) begin n_errors++; $display("FAIL rnd_leds[%0d]: got %h want %h", i, leds_o, m_led); end
      n_checks++; if (an !== exp_an() || segs !== exp_segs()) begin
        n_errors++; $display("FAIL rnd_disp[%0d]: an=%h segs=%h want %h %h", i, an, segs, exp_an(), exp_segs()); end
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_write(A_TL, 32'h55);
    bus_write(A_TCON, 32'd3);
    bus_write(A_LED, 32'h5A);
    bus_write(A_DISP, 32'h1234_5678);
    repeat (3) tick();
    #2 reset = 1'b1;
    m_reset();
    #1;
    drive(1'b0, 1'b1, 1'b1, A_TL, 32'd0);
    n_checks++; if (rdata !== 32'd0 || irq !== 1'b0 || leds_o !== '0) begin
      n_errors++; $display("FAIL midreset_regs: tl=%h irq=%b leds=%h want 0 0 0", rdata, irq, leds_o); end
    n_checks++; if (an !== RST_AN || segs !== RST_SEGS) begin
      n_errors++; $display("FAIL midreset_disp: an=%h segs=%h want %h %h", an, segs, RST_AN, RST_SEGS); end
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, A_TICK, 32'd0);
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (rdata !== 32'(c)) begin n_errors++; $display("FAIL tick_after_reset[%0d]: got %h want %h", c, rdata, c); end
      tick();
    end
    bus_write(A_TICK, 32'h100);
    drive(1'b0, 1'b1, 1'b1, A_TICK, 32'd0);
    n_checks++; if (rdata !== 32'd4) begin n_errors++; $display("FAIL tick_write_ignored: got %h want 4", rdata); end
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_mem_route();
    test_timer();
    test_tl_write();
    test_led();
    test_display();
    test_systick();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
